// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, multi-cycle
// mul/div holds and two-cycle branch redirects, with saturating activity counters.
module pipeline_stall_controller #(
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bubble_enable,
  input  logic             branch_taken,
  input  logic             muldiv_start,
  input  logic             muldiv_done,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             id_ex_write_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [15:0]      flush_count,
  output logic [1:0]       dbg_state_o,
  output logic [5:0]       dbg_md_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [5:0] MD_LAST = 6'(MD_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [5:0]         md_cnt_q, md_cnt_d;
  logic               md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [15:0]        flush_cnt_q;
  logic               flush_inc;

  always_comb begin
    state_d        = state_q;
    md_cnt_d       = md_cnt_q;
    md_timeout_d   = md_timeout_q;
    flush_inc      = 1'b0;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    id_ex_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_bubble  = 1'b0;

    if (reset) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      ex_mem_bubble  = 1'b1;
      state_d        = RUN;
      md_cnt_d       = 6'd0;
      md_timeout_d   = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bubble_enable || (muldiv_start && !muldiv_done)) begin
            // Hold PC..ID/EX; the instruction ahead drains while EX/MEM gets a NOP.
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_write_en = 1'b0;
            ex_mem_bubble  = 1'b1;
            if (!bubble_enable) begin
              state_d  = MD_WAIT;
              md_cnt_d = 6'd1;
            end
          end else if (muldiv_start) begin
            state_d = RUN;
          end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
            state_d     = REDIRECT;
          end
        end
        MD_WAIT: begin
          if (muldiv_done) begin
            state_d  = RUN;
            md_cnt_d = 6'd0;
          end else if (md_cnt_q == MD_LAST) begin
            md_timeout_d = 1'b1;
            state_d      = RUN;
            md_cnt_d     = 6'd0;
          end else begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_write_en = 1'b0;
            ex_mem_bubble  = 1'b1;
            md_cnt_d       = md_cnt_q + 6'd1;
          end
        end
        REDIRECT: begin
          // Kill the wrong-path word still coming out of the synchronous I-memory.
          if_id_flush = 1'b1;
          state_d     = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    md_cnt_q     <= md_cnt_d;
    md_timeout_q <= md_timeout_d;
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write_en && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc && (flush_cnt_q != 16'hFFFF))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign md_timeout   = md_timeout_q;
  assign stall_count  = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
  assign dbg_state_o  = state_q;
  assign dbg_md_cnt_o = md_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: every cycle's control pattern and
// the registered counters are checked against hand-computed values.
module tb_pipeline_stall_controller;

  localparam int MD_TIMEOUT = 40;
  localparam int CNT_W      = 32;

  // Control vector order: {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, ex_mem_bubble}
  localparam logic [5:0] C_DEF   = 6'b111000;
  localparam logic [5:0] C_HOLD  = 6'b000001;
  localparam logic [5:0] C_RST   = 6'b000111;
  localparam logic [5:0] C_BR    = 6'b111110;
  localparam logic [5:0] C_REDIR = 6'b111100;

  localparam int S_RUN = 0, S_MD = 1, S_RED = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             bubble_enable, branch_taken, muldiv_start, muldiv_done;
  logic             pc_write_en, if_id_write_en, id_ex_write_en;
  logic             if_id_flush, id_ex_flush, ex_mem_bubble, md_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [15:0]      flush_count;
  logic [1:0]       dbg_state_o;
  logic [5:0]       dbg_md_cnt_o;
  logic [5:0]       ctl;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .bubble_enable  (bubble_enable),
    .branch_taken   (branch_taken),
    .muldiv_start   (muldiv_start),
    .muldiv_done    (muldiv_done),
    .pc_write_en    (pc_write_en),
    .if_id_write_en (if_id_write_en),
    .id_ex_write_en (id_ex_write_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_bubble  (ex_mem_bubble),
    .md_timeout     (md_timeout),
    .stall_count    (stall_count),
    .flush_count    (flush_count),
    .dbg_state_o    (dbg_state_o),
    .dbg_md_cnt_o   (dbg_md_cnt_o)
  );

  assign ctl = {pc_write_en, if_id_write_en, id_ex_write_en,
                if_id_flush, id_ex_flush, ex_mem_bubble};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Apply inputs for one cycle, check the combinational controls mid-cycle,
  // then move just past the next rising edge.
  task automatic drive_cycle(input logic rst, input logic bub, input logic br,
                             input logic ms, input logic md,
                             input string tag, input logic [5:0] exp_ctl);
    reset         = rst;
    bubble_enable = bub;
    branch_taken  = br;
    muldiv_start  = ms;
    muldiv_done   = md;
    @(negedge clk);
    check(tag, 32'(ctl), 32'(exp_ctl));
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input int st, input int stalls,
                            input int flushes, input logic tmo);
    check({tag, ".state"}, 32'(dbg_state_o), 32'(st));
    check({tag, ".stall"}, stall_count, 32'(stalls));
    check({tag, ".flush"}, 32'(flush_count), 32'(flushes));
    check({tag, ".tmo"},   32'(md_timeout), 32'(tmo));
  endtask

  initial begin
    reset = 1'b1; bubble_enable = 1'b0; branch_taken = 1'b0;
    muldiv_start = 1'b0; muldiv_done = 1'b0;
    @(posedge clk); #1;

    // Reset pattern regardless of inputs.
    drive_cycle(1, 0, 0, 0, 0, "rst0", C_RST);
    drive_cycle(1, 1, 1, 1, 0, "rst1", C_RST);
    check_regs("after_rst", S_RUN, 0, 0, 0);
    check("after_rst.md_cnt", 32'(dbg_md_cnt_o), 0);

    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 0, "idle", C_DEF);
    check_regs("idle", S_RUN, 0, 0, 0);

    // Load bubble: one stall cycle.
    drive_cycle(0, 1, 0, 0, 0, "bubble", C_HOLD);
    check_regs("bubble", S_RUN, 1, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, "post_bubble", C_DEF);

    // Mul/div done 4 cycles after start: stall t..t+3, release at t+4.
    drive_cycle(0, 0, 0, 1, 0, "md_start", C_HOLD);
    check("md_start.state", 32'(dbg_state_o), S_MD);
    check("md_start.cnt", 32'(dbg_md_cnt_o), 1);
    drive_cycle(0, 0, 0, 0, 0, "md_w1", C_HOLD);
    drive_cycle(0, 1, 1, 0, 0, "md_w2_ignore", C_HOLD);
    check("md_w2.cnt", 32'(dbg_md_cnt_o), 3);
    drive_cycle(0, 0, 0, 0, 0, "md_w3", C_HOLD);
    drive_cycle(0, 0, 0, 0, 1, "md_done", C_DEF);
    check_regs("md_done", S_RUN, 5, 0, 0);
    check("md_done.cnt", 32'(dbg_md_cnt_o), 0);

    // Single-cycle mul/div outranks a branch.
    drive_cycle(0, 0, 1, 1, 1, "md_fast_br", C_DEF);
    check_regs("md_fast", S_RUN, 5, 0, 0);
    drive_cycle(0, 0, 0, 0, 1, "stray_done", C_DEF);

    // No done: release when md_cnt reaches MD_TIMEOUT-1.
    drive_cycle(0, 0, 0, 1, 0, "tmo_start", C_HOLD);
    for (int k = 1; k < MD_TIMEOUT - 1; k++) drive_cycle(0, 0, 0, 0, 0, "tmo_wait", C_HOLD);
    check("tmo_last.cnt", 32'(dbg_md_cnt_o), 32'(MD_TIMEOUT - 1));
    drive_cycle(0, 0, 0, 0, 0, "tmo_release", C_DEF);
    check_regs("tmo", S_RUN, 5 + MD_TIMEOUT - 1, 0, 1);
    drive_cycle(0, 0, 0, 0, 0, "tmo_idle", C_DEF);
    check("tmo_sticky", 32'(md_timeout), 1);

    // Branch with bubble: bubble wins, no flush.
    drive_cycle(0, 1, 1, 0, 0, "br_bub", C_HOLD);
    check_regs("br_bub", S_RUN, 5 + MD_TIMEOUT, 0, 1);

    // Lone branch, with a back-to-back branch ignored in REDIRECT.
    drive_cycle(0, 0, 1, 0, 0, "branch", C_BR);
    check_regs("branch", S_RED, 5 + MD_TIMEOUT, 1, 1);
    drive_cycle(0, 1, 1, 1, 0, "redirect", C_REDIR);
    check_regs("redirect", S_RUN, 5 + MD_TIMEOUT, 1, 1);
    drive_cycle(0, 0, 0, 0, 0, "post_redir", C_DEF);

    // Reset in the third MD_WAIT cycle.
    drive_cycle(0, 0, 0, 1, 0, "rmd_start", C_HOLD);
    drive_cycle(0, 0, 0, 0, 0, "rmd_w1", C_HOLD);
    drive_cycle(0, 0, 0, 0, 0, "rmd_w2", C_HOLD);
    check("rmd_w3.state", 32'(dbg_state_o), S_MD);
    drive_cycle(1, 0, 0, 0, 0, "rmd_reset", C_RST);
    check_regs("rmd", S_RUN, 0, 0, 0);
    check("rmd.cnt", 32'(dbg_md_cnt_o), 0);
    drive_cycle(0, 0, 0, 0, 0, "rmd_run", C_DEF);
    check_regs("rmd_run", S_RUN, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
